// File: rtl/alu_seq_if.sv
// Bundles the request/response handshake and the 16-bit ALU side-band into one
// interface so the sequencer and its environment connect through modports.
//   master : requester + ALU model (drives req_*, rsp_ready, alu_out, alu_flags)
//   slave  : the sequencer (drives req_ready, rsp_*, alu_a/b, alu_fun_sel, alu_wf)
interface alu_seq_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned FUN_W  = 5;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned OP_W   = 2;

  // Request channel
  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [FLAG_W-1:0] rsp_flags;

  // 16-bit ALU connection; alu_flags is the ALU's own registered {Z,C,N,O}
  logic [HALF_W-1:0] alu_a;
  logic [HALF_W-1:0] alu_b;
  logic [FUN_W-1:0]  alu_fun_sel;
  logic              alu_wf;
  logic [HALF_W-1:0] alu_out;
  logic [FLAG_W-1:0] alu_flags;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_flags,
    input  req_ready, rsp_valid, rsp_result, rsp_flags,
           alu_a, alu_b, alu_fun_sel, alu_wf
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_flags,
    output req_ready, rsp_valid, rsp_result, rsp_flags,
           alu_a, alu_b, alu_fun_sel, alu_wf
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Runs 32-bit ADD / LSL / LSR / ASR operations as two passes through an
// external 16-bit ALU, chaining the carry through the ALU's flag register.
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_ni : synchronous active-low reset
//   bus    : alu_seq_if.slave -- request/response handshake and ALU drive
module alu_op_sequencer (
  input  logic      clk_i,
  input  logic      rst_ni,
  alu_seq_if.slave  bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned FUN_W  = 5;
  localparam int unsigned OP_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_LSL = 2'b01;
  localparam logic [OP_W-1:0] OP_LSR = 2'b10;
  localparam logic [OP_W-1:0] OP_ASR = 2'b11;

  localparam logic [FUN_W-1:0] FS_NOP = 5'b10000;
  localparam logic [FUN_W-1:0] FS_ADD = 5'b10100;
  localparam logic [FUN_W-1:0] FS_ADC = 5'b10101;
  localparam logic [FUN_W-1:0] FS_LSL = 5'b11011;
  localparam logic [FUN_W-1:0] FS_LSR = 5'b11100;
  localparam logic [FUN_W-1:0] FS_ASR = 5'b11101;
  localparam logic [FUN_W-1:0] FS_RLC = 5'b11110;
  localparam logic [FUN_W-1:0] FS_RRC = 5'b11111;

  // ALU flag bit positions within {Z,C,N,O}
  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_O = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                z_q, z_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [HALF_W-1:0]   alu_a_q, alu_a_d;
  logic [HALF_W-1:0]   alu_b_q, alu_b_d;
  logic [FUN_W-1:0]    alu_fun_q, alu_fun_d;
  logic                alu_wf_q, alu_wf_d;

  logic                accept;
  logic                shift_right_q;
  logic                unused_alu_n;

  assign accept        = bus.req_valid & req_ready_q;
  // Right shifts process the high half first, so pass results land swapped
  assign shift_right_q = op_q[1];
  // The ALU's N flag is not needed: N is taken from the assembled result
  assign unused_alu_n  = bus.alu_flags[1];

  // Next-state, operand capture and registered ALU drive
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    z_d       = z_q;
    alu_a_d   = '0;
    alu_b_d   = '0;
    alu_fun_d = FS_NOP;
    alu_wf_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PASS1;
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
        end
      end
      PASS1: begin
        state_d = PASS2;
        if (shift_right_q) result_d[DATA_W-1:HALF_W] = bus.alu_out;
        else               result_d[HALF_W-1:0]      = bus.alu_out;
      end
      PASS2: begin
        state_d = RESP;
        if (shift_right_q) result_d[HALF_W-1:0]      = bus.alu_out;
        else               result_d[DATA_W-1:HALF_W] = bus.alu_out;
        // Flags seen here were written by PASS1; combine with this pass's half
        z_d = bus.alu_flags[FLG_Z] & (bus.alu_out == HALF_W'(0));
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // ALU inputs are registered, so they are chosen from the state being entered
    case (state_d)
      PASS1: begin
        alu_wf_d = 1'b1;
        case (op_d)
          OP_ADD: begin
            alu_a_d   = a_d[HALF_W-1:0];
            alu_b_d   = b_d[HALF_W-1:0];
            alu_fun_d = FS_ADD;
          end
          OP_LSL: begin
            alu_a_d   = a_d[HALF_W-1:0];
            alu_fun_d = FS_LSL;
          end
          OP_LSR: begin
            alu_a_d   = a_d[DATA_W-1:HALF_W];
            alu_fun_d = FS_LSR;
          end
          default: begin
            alu_a_d   = a_d[DATA_W-1:HALF_W];
            alu_fun_d = FS_ASR;
          end
        endcase
      end
      PASS2: begin
        alu_wf_d = 1'b1;
        case (op_d)
          OP_ADD: begin
            alu_a_d   = a_d[DATA_W-1:HALF_W];
            alu_b_d   = b_d[DATA_W-1:HALF_W];
            alu_fun_d = FS_ADC;
          end
          OP_LSL: begin
            alu_a_d   = a_d[DATA_W-1:HALF_W];
            alu_fun_d = FS_RLC;
          end
          default: begin
            alu_a_d   = a_d[HALF_W-1:0];
            alu_fun_d = FS_RRC;
          end
        endcase
      end
      default: ;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers; reset discards any operation in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      z_q         <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= FS_NOP;
      alu_wf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      z_q         <= z_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      alu_wf_q    <= alu_wf_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = result_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_fun_sel = alu_fun_q;
  assign bus.alu_wf      = alu_wf_q;

  // C and O come from the ALU flag register written by PASS2; the ALU is not
  // written again while in RESP, so these stay stable until the handshake.
  assign bus.rsp_flags = rsp_valid_q
                       ? {z_q,
                          bus.alu_flags[FLG_C],
                          result_q[DATA_W-1],
                          (op_q == OP_ADD) & bus.alu_flags[FLG_O]}
                       : 4'b0000;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LSL = 2'b01;
  localparam logic [1:0] OP_LSR = 2'b10;
  localparam logic [1:0] OP_ASR = 2'b11;

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  alu_seq_if bus();

  alu_op_sequencer dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // 16-bit ALU environment model with a registered {Z,C,N,O} flag register
  logic [3:0]  alu_flags_q = 4'b0000;
  logic [16:0] m_sum;
  logic [15:0] m_out;
  logic        m_c, m_o;

  always_comb begin
    m_sum = '0;
    m_out = bus.alu_a;
    m_c   = alu_flags_q[2];
    m_o   = 1'b0;
    case (bus.alu_fun_sel)
      5'b10100, 5'b10101: begin
        m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}
              + ((bus.alu_fun_sel == 5'b10101) ? {16'd0, alu_flags_q[2]} : 17'd0);
        m_out = m_sum[15:0];
        m_c   = m_sum[16];
        m_o   = (bus.alu_a[15] == bus.alu_b[15]) && (m_out[15] != bus.alu_a[15]);
      end
      5'b11011: begin m_out = {bus.alu_a[14:0], 1'b0};           m_c = bus.alu_a[15]; end
      5'b11110: begin m_out = {bus.alu_a[14:0], alu_flags_q[2]}; m_c = bus.alu_a[15]; end
      5'b11100: begin m_out = {1'b0, bus.alu_a[15:1]};           m_c = bus.alu_a[0];  end
      5'b11101: begin m_out = {bus.alu_a[15], bus.alu_a[15:1]};  m_c = bus.alu_a[0];  end
      5'b11111: begin m_out = {alu_flags_q[2], bus.alu_a[15:1]}; m_c = bus.alu_a[0];  end
      default: ;
    endcase
  end

  assign bus.alu_out   = m_out;
  assign bus.alu_flags = alu_flags_q;

  always @(posedge clk) begin
    if (bus.alu_wf) alu_flags_q <= {m_out == 16'd0, m_c, m_out[15], m_o};
  end

  // Reference 32-bit result and {Z,C,N,O}
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, o;
    exp_t        e;
    o = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_LSL:  begin r = {a[30:0], 1'b0};  c = a[31]; end
      OP_LSR:  begin r = {1'b0, a[31:1]};  c = a[0];  end
      default: begin r = {a[31], a[31:1]}; c = a[0];  end
    endcase
    e.r = r;
    e.f = {r == 32'd0, c, r[31], o};
    return e;
  endfunction

  // Push expectation, present request from a negedge and complete the handshake
  task automatic send_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output bit to);
    sb_q.push_back(model(op, a, b));
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Count negedges until rsp_valid is seen, bounded
  task automatic wait_rsp(output int lat, output bit to);
    to  = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic ack_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready);
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid);
    end
    n_checks++;
    if ({bus.rsp_result, bus.rsp_flags} !== 36'd0) begin
      n_fail++; $display("FAIL reset_rsp_data: got %h/%b expected 0/0", bus.rsp_result, bus.rsp_flags);
    end
    n_checks++;
    if ({bus.alu_wf, bus.alu_fun_sel, bus.alu_a, bus.alu_b} !== {1'b0, 5'b10000, 32'd0}) begin
      n_fail++; $display("FAIL reset_alu_drive: got wf=%b fs=%b a=%h b=%h expected 0/10000/0/0",
                         bus.alu_wf, bus.alu_fun_sel, bus.alu_a, bus.alu_b);
    end
  endtask

  task automatic test_add();
    logic [31:0] va[6];
    logic [31:0] vb[6];
    exp_t e;
    int   lat;
    bit   to;
    va = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, $urandom, $urandom};
    vb = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h80000000, $urandom, $urandom};
    for (int i = 0; i < 6; i++) begin
      send_req(OP_ADD, va[i], vb[i], to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL add_accept[%0d]: req_ready never 1 expected accept", i); end
      @(negedge clk);
      n_checks++;
      if ({bus.alu_wf, bus.alu_fun_sel, bus.alu_a, bus.alu_b} !== {1'b1, 5'b10100, va[i][15:0], vb[i][15:0]}) begin
        n_fail++; $display("FAIL add_pass1[%0d]: got wf=%b fs=%b a=%h b=%h expected 1/10100/%h/%h",
                           i, bus.alu_wf, bus.alu_fun_sel, bus.alu_a, bus.alu_b, va[i][15:0], vb[i][15:0]);
      end
      @(negedge clk);
      n_checks++;
      if ({bus.alu_wf, bus.alu_fun_sel, bus.alu_a, bus.alu_b} !== {1'b1, 5'b10101, va[i][31:16], vb[i][31:16]}) begin
        n_fail++; $display("FAIL add_pass2[%0d]: got wf=%b fs=%b a=%h b=%h expected 1/10101/%h/%h",
                           i, bus.alu_wf, bus.alu_fun_sel, bus.alu_a, bus.alu_b, va[i][31:16], vb[i][31:16]);
      end
      wait_rsp(lat, to);
      n_checks++;
      if (to || lat != 1) begin
        n_fail++; $display("FAIL add_latency[%0d]: got %0d cycles (timeout=%0b) expected 3", i, lat + 2, to);
      end
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      n_checks++;
      if (bus.rsp_result !== e.r) begin
        n_fail++; $display("FAIL add_result[%0d]: got %h expected %h", i, bus.rsp_result, e.r);
      end
      n_checks++;
      if (bus.rsp_flags !== e.f) begin
        n_fail++; $display("FAIL add_flags[%0d]: got %b expected %b", i, bus.rsp_flags, e.f);
      end
      n_checks++;
      if ({bus.alu_wf, bus.alu_fun_sel, bus.alu_a, bus.alu_b} !== {1'b0, 5'b10000, 32'd0}) begin
        n_fail++; $display("FAIL add_resp_alu_idle[%0d]: got wf=%b fs=%b expected 0/10000", i, bus.alu_wf, bus.alu_fun_sel);
      end
      ack_rsp();
    end
  endtask

  task automatic test_shift();
    logic [1:0]  vop[9];
    logic [31:0] va[9];
    logic [4:0]  f1, f2;
    logic [15:0] a1, a2;
    exp_t e;
    int   lat;
    bit   to;
    vop = '{OP_LSL, OP_LSR, OP_ASR, OP_LSL, OP_LSR, OP_ASR, OP_ASR, OP_LSL, OP_LSR};
    va  = '{32'h80008000, 32'h00010001, 32'h80000000, $urandom, $urandom, $urandom,
            32'h00000001, 32'h00000000, $urandom};
    for (int i = 0; i < 9; i++) begin
      f1 = (vop[i] == OP_LSL) ? 5'b11011 : (vop[i] == OP_LSR) ? 5'b11100 : 5'b11101;
      f2 = (vop[i] == OP_LSL) ? 5'b11110 : 5'b11111;
      a1 = (vop[i] == OP_LSL) ? va[i][15:0]  : va[i][31:16];
      a2 = (vop[i] == OP_LSL) ? va[i][31:16] : va[i][15:0];
      send_req(vop[i], va[i], $urandom, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL shift_accept[%0d]: req_ready never 1 expected accept", i); end
      @(negedge clk);
      n_checks++;
      if ({bus.alu_wf, bus.alu_fun_sel, bus.alu_a, bus.alu_b} !== {1'b1, f1, a1, 16'd0}) begin
        n_fail++; $display("FAIL shift_pass1[%0d]: got wf=%b fs=%b a=%h b=%h expected 1/%b/%h/0",
                           i, bus.alu_wf, bus.alu_fun_sel, bus.alu_a, bus.alu_b, f1, a1);
      end
      @(negedge clk);
      n_checks++;
      if ({bus.alu_wf, bus.alu_fun_sel, bus.alu_a, bus.alu_b} !== {1'b1, f2, a2, 16'd0}) begin
        n_fail++; $display("FAIL shift_pass2[%0d]: got wf=%b fs=%b a=%h b=%h expected 1/%b/%h/0",
                           i, bus.alu_wf, bus.alu_fun_sel, bus.alu_a, bus.alu_b, f2, a2);
      end
      wait_rsp(lat, to);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      n_checks++;
      if (to || lat != 1 || bus.rsp_result !== e.r || bus.rsp_flags !== e.f) begin
        n_fail++; $display("FAIL shift_rsp[%0d]: got lat=%0d res=%h flags=%b expected lat=3 res=%h flags=%b",
                           i, lat + 2, bus.rsp_result, bus.rsp_flags, e.r, e.f);
      end
      ack_rsp();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    bit   to;
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    send_req(OP_ADD, a, b, to);
    wait_rsp(lat, to);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_checks++;
    if (to || bus.rsp_result !== e.r || bus.rsp_flags !== e.f) begin
      n_fail++; $display("FAIL bp_first: got res=%h flags=%b to=%0b expected res=%h flags=%b",
                         bus.rsp_result, bus.rsp_flags, to, e.r, e.f);
    end
    // A competing request is held pending while the response is stalled
    bus.req_valid = 1'b1;
    bus.req_op    = OP_LSL;
    bus.req_a     = a;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_flags} !== {1'b1, 1'b0, e.r, e.f}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b rdy=%b res=%h flags=%b expected 1/0/%h/%b",
                           c, bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_flags, e.r, e.f);
      end
    end
    ack_rsp();
    n_checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release: got v=%b rdy=%b expected v=0 rdy=1", bus.rsp_valid, bus.req_ready);
    end
    send_req(OP_LSL, a, 32'd0, to);
    wait_rsp(lat, to);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_checks++;
    if (to || lat != 3 || bus.rsp_result !== e.r || bus.rsp_flags !== e.f) begin
      n_fail++; $display("FAIL bp_next: got lat=%0d res=%h flags=%b expected lat=3 res=%h flags=%b",
                         lat, bus.rsp_result, bus.rsp_flags, e.r, e.f);
    end
    ack_rsp();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    bit   to;
    send_req(OP_ADD, 32'h1234FFFF, 32'h00000001, to);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;  // operation is discarded
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_flags} !== {1'b0, 1'b1, 36'd0}) begin
      n_fail++; $display("FAIL midrst_rsp: got v=%b rdy=%b res=%h flags=%b expected 0/1/0/0",
                         bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_flags);
    end
    n_checks++;
    if ({bus.alu_wf, bus.alu_fun_sel, bus.alu_a, bus.alu_b} !== {1'b0, 5'b10000, 32'd0}) begin
      n_fail++; $display("FAIL midrst_alu: got wf=%b fs=%b a=%h b=%h expected 0/10000/0/0",
                         bus.alu_wf, bus.alu_fun_sel, bus.alu_a, bus.alu_b);
    end
    lat = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) lat++;
    end
    n_checks++;
    if (lat != 0) begin n_fail++; $display("FAIL midrst_no_rsp: got %0d valid cycles expected 0", lat); end
    send_req(OP_ADD, 32'h0000FFFF, 32'h00000001, to);
    wait_rsp(lat, to);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_checks++;
    if (to || lat != 3 || bus.rsp_result !== e.r || bus.rsp_flags !== e.f) begin
      n_fail++; $display("FAIL midrst_next_add: got lat=%0d res=%h flags=%b expected lat=3 res=%h flags=%b",
                         lat, bus.rsp_result, bus.rsp_flags, e.r, e.f);
    end
    ack_rsp();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    bit   to;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_req(2'($urandom_range(0, 3)), $urandom, $urandom, to);
      wait_rsp(lat, to);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      n_checks++;
      if (to || lat != 3 || bus.rsp_result !== e.r || bus.rsp_flags !== e.f) begin
        n_fail++; $display("FAIL b2b[%0d]: got lat=%0d res=%h flags=%b expected lat=3 res=%h flags=%b",
                           i, lat, bus.rsp_result, bus.rsp_flags, e.r, e.f);
      end
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: got queue=%0d v=%b expected 0/0", sb_q.size(), bus.rsp_valid);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = OP_ADD;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_shift();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
